// File: rtl/swipt_rx_freq_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// swipt_rx_freq_meter : frequency (Hz) and peak-to-peak amplitude of the ADC
//                       waveform received over the SWIPT link.
// Revision 1.0
// ----------------------------------------------------------------------------
module swipt_rx_freq_meter #(
    parameter int CLK_HZ  = 100000000,
    parameter int NPER    = 8,
    parameter int HYST    = 64,
    parameter int MIN_PER = 200,
    parameter int MAX_PER = 20000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [11:0] adc,
    output logic [19:0] meas_freq,
    output logic [11:0] amp_pp,
    output logic        meas_valid,
    output logic        busy,
    output logic        no_signal,
    output logic        glitch
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ARM    = 3'd1;
    localparam logic [2:0] c_SYNC   = 3'd2;
    localparam logic [2:0] c_COUNT  = 3'd3;
    localparam logic [2:0] c_DIVIDE = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    localparam int                c_NW       = $clog2(NPER + 1);
    localparam logic [c_NW-1:0]   c_NPER     = c_NW'(NPER);
    localparam logic [c_NW-1:0]   c_N_ONE    = c_NW'(1);
    localparam logic [29:0]       c_DIVIDEND = 30'(CLK_HZ * NPER);
    localparam logic [12:0]       c_HYST     = 13'(HYST);
    localparam logic [19:0]       c_MIN_PER  = 20'(MIN_PER);
    localparam logic [19:0]       c_MAX_PER  = 20'(MAX_PER);

    logic [2:0]      r_state;
    logic [11:0]     r_adc_q;
    logic [11:0]     r_mid;
    logic            r_arm;
    logic [19:0]     r_wait;
    logic [19:0]     r_per;
    logic [19:0]     r_tot;
    logic [c_NW-1:0] r_n;
    logic [11:0]     r_min;
    logic [11:0]     r_max;
    logic [29:0]     r_dvd;
    logic [19:0]     r_rem;
    logic [28:0]     r_quo;
    logic [4:0]      r_bit;
    logic [19:0]     r_freq;
    logic [11:0]     r_amp;
    logic            r_valid;
    logic            r_nosig;
    logic            r_glitch;

    logic [12:0]     w_lo13;
    logic [12:0]     w_hi13;
    logic [11:0]     w_lo;
    logic [11:0]     w_hi;
    logic            w_below;
    logic            w_rise;
    logic [19:0]     w_per_inc;
    logic [19:0]     w_wait_inc;
    logic [c_NW-1:0] w_n_inc;
    logic            w_short;
    logic            w_timeout;
    logic [20:0]     w_rem_sh;
    logic            w_ge;
    logic [19:0]     w_sub;
    logic [29:0]     w_quo_nxt;
    logic [11:0]     w_mid;

    // Thresholds are formed at 13 bits so under/overflow of mid+-HYST clamps.
    assign w_lo13     = {1'b0, r_mid} - c_HYST;
    assign w_hi13     = {1'b0, r_mid} + c_HYST;
    assign w_lo       = w_lo13[12] ? 12'h000 : w_lo13[11:0];
    assign w_hi       = w_hi13[12] ? 12'hFFF : w_hi13[11:0];
    assign w_below    = (r_adc_q < w_lo);
    assign w_rise     = r_arm && (r_adc_q > w_hi);

    assign w_per_inc  = r_per + 20'd1;
    assign w_wait_inc = r_wait + 20'd1;
    assign w_n_inc    = r_n + c_N_ONE;
    assign w_short    = (w_per_inc < c_MIN_PER);
    assign w_timeout  = (r_wait >= c_MAX_PER);

    // One restoring-division step; the remainder always stays below tot_cnt.
    assign w_rem_sh   = {r_rem, r_dvd[29]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_tot});
    assign w_sub      = w_rem_sh[19:0] - r_tot;
    assign w_quo_nxt  = {r_quo, w_ge};
    assign w_mid      = 12'(({1'b0, r_max} + {1'b0, r_min}) >> 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_adc_q <= 12'h800;
            r_arm   <= 1'b0;
        end else begin
            r_adc_q <= adc;
            if (w_rise) begin
                r_arm <= 1'b0;
            end else if (w_below) begin
                r_arm <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= c_IDLE;
            r_wait   <= '0;
            r_per    <= '0;
            r_tot    <= '0;
            r_n      <= '0;
            r_min    <= '0;
            r_max    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_bit    <= '0;
            r_mid    <= 12'h800;
            r_freq   <= '0;
            r_amp    <= '0;
            r_valid  <= 1'b0;
            r_nosig  <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_glitch <= 1'b0;
            if (!en) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_ARM;
                        r_wait  <= '0;
                    end
                    c_ARM: begin
                        r_wait <= w_wait_inc;
                        if (w_timeout) begin
                            r_nosig <= 1'b1;
                            r_wait  <= '0;
                        end else if (r_arm) begin
                            r_state <= c_SYNC;
                            r_wait  <= '0;
                        end
                    end
                    c_SYNC: begin
                        r_wait <= w_wait_inc;
                        if (w_timeout) begin
                            r_nosig <= 1'b1;
                            r_state <= c_ARM;
                            r_wait  <= '0;
                        end else if (w_rise) begin
                            r_state <= c_COUNT;
                            r_wait  <= '0;
                            r_per   <= '0;
                            r_tot   <= '0;
                            r_n     <= '0;
                            r_min   <= r_adc_q;
                            r_max   <= r_adc_q;
                        end
                    end
                    c_COUNT: begin
                        r_per  <= w_per_inc;
                        r_tot  <= r_tot + 20'd1;
                        r_wait <= w_wait_inc;
                        if (r_adc_q < r_min) r_min <= r_adc_q;
                        if (r_adc_q > r_max) r_max <= r_adc_q;
                        if (w_timeout) begin
                            r_nosig <= 1'b1;
                            r_state <= c_ARM;
                            r_wait  <= '0;
                        end else if (w_rise) begin
                            r_wait <= '0;
                            if (w_short) begin
                                r_glitch <= 1'b1;
                                r_state  <= c_ARM;
                            end else begin
                                r_per <= '0;
                                r_n   <= w_n_inc;
                                if (w_n_inc == c_NPER) begin
                                    r_state <= c_DIVIDE;
                                    r_dvd   <= c_DIVIDEND;
                                    r_rem   <= '0;
                                    r_quo   <= '0;
                                    r_bit   <= '0;
                                end
                            end
                        end
                    end
                    c_DIVIDE: begin
                        r_dvd <= {r_dvd[28:0], 1'b0};
                        r_rem <= w_ge ? w_sub : w_rem_sh[19:0];
                        r_quo <= w_quo_nxt[28:0];
                        r_bit <= r_bit + 5'd1;
                        // Results land with the final quotient bit so they are visible during DONE.
                        if (r_bit == 5'd29) begin
                            r_state <= c_DONE;
                            r_freq  <= (|w_quo_nxt[29:20]) ? 20'hFFFFF : w_quo_nxt[19:0];
                            r_amp   <= r_max - r_min;
                            r_mid   <= w_mid;
                            r_valid <= 1'b1;
                            r_nosig <= 1'b0;
                        end
                    end
                    c_DONE: begin
                        r_state <= c_ARM;
                        r_wait  <= '0;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign meas_freq  = r_freq;
    assign amp_pp     = r_amp;
    assign meas_valid = r_valid;
    assign busy       = (r_state != c_IDLE);
    assign no_signal  = r_nosig;
    assign glitch     = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_swipt_rx_freq_meter.sv
`default_nettype none
// tb_swipt_rx_freq_meter : directed checks of the receive frequency meter, run
// with a 10 MHz model clock so every period and timeout is 10x shorter.
module tb_swipt_rx_freq_meter;

    localparam int CLK_HZ  = 10000000;
    localparam int NPER    = 8;
    localparam int HYST    = 64;
    localparam int MIN_PER = 20;
    localparam int MAX_PER = 2000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [11:0] adc;
    logic [19:0] meas_freq;
    logic [11:0] amp_pp;
    logic        meas_valid;
    logic        busy;
    logic        no_signal;
    logic        glitch;

    int nchecks  = 0;
    int nerr     = 0;
    int cyc      = 0;
    int nvalid   = 0;
    int nglitch  = 0;
    int last_vt  = 0;
    int prev_vt  = 0;
    int rise_cyc = 0;

    swipt_rx_freq_meter #(
        .CLK_HZ  (CLK_HZ),
        .NPER    (NPER),
        .HYST    (HYST),
        .MIN_PER (MIN_PER),
        .MAX_PER (MAX_PER)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .adc        (adc),
        .meas_freq  (meas_freq),
        .amp_pp     (amp_pp),
        .meas_valid (meas_valid),
        .busy       (busy),
        .no_signal  (no_signal),
        .glitch     (glitch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold adc for n cycles, sampling pulses on each falling edge.
    task automatic step(input logic [11:0] a, input int n);
        adc = a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (meas_valid === 1'b1) begin
                nvalid++;
                prev_vt = last_vt;
                last_vt = cyc;
            end
            if (glitch === 1'b1) nglitch++;
        end
    endtask

    task automatic square(input logic [11:0] lo, input logic [11:0] hi, input int half, input int n);
        for (int p = 0; p < n; p++) begin
            step(lo, half);
            step(hi, half);
        end
    endtask

    task automatic restart(input logic [11:0] lvl);
        en = 1'b0;
        step(lvl, 3);
        en = 1'b1;
    endtask

    initial begin
        nrst = 1'b0;
        en   = 1'b0;
        adc  = 12'h800;
        step(12'h800, 3);
        chk("rst_freq",   meas_freq,  0);
        chk("rst_amp",    amp_pp,     0);
        chk("rst_valid",  meas_valid, 0);
        chk("rst_busy",   busy,       0);
        chk("rst_nosig",  no_signal,  0);
        chk("rst_glitch", glitch,     0);
        nrst = 1'b1;
        step(12'h800, 2);

        // 40 kHz: 250-cycle period, first rise syncs, ninth rise completes the window
        restart(12'h100);
        nvalid = 0;
        square(12'h100, 12'hF00, 125, 8);
        step(12'h100, 125);
        rise_cyc = cyc;
        step(12'hF00, 125);
        chk("f40_count",   nvalid,             1);
        chk("f40_freq",    meas_freq,          20'h09C40);
        chk("f40_amp",     amp_pp,             12'hE00);
        chk("f40_nosig",   no_signal,          0);
        chk("f40_latency", last_vt - rise_cyc, 32);
        chk("f40_mid",     dut.r_mid,          12'h800);

        // 50 kHz: a window restarts on the rise after the one that ended it
        nvalid = 0;
        square(12'h200, 12'hE00, 100, 20);
        chk("f50_count",   nvalid,            2);
        chk("f50_freq",    meas_freq,         20'h0C350);
        chk("f50_amp",     amp_pp,            12'hC00);
        chk("f50_spacing", last_vt - prev_vt, 1800);

        // enable dropped after three counted periods
        restart(12'h100);
        nvalid = 0;
        square(12'h100, 12'hF00, 125, 4);
        chk("endrop_busy_before", busy, 1);
        en = 1'b0;
        step(12'h100, 1);
        chk("endrop_busy_after", busy, 0);
        step(12'h100, 124);
        square(12'h100, 12'hF00, 125, 4);
        chk("endrop_novalid", nvalid,    0);
        chk("endrop_hold_f",  meas_freq, 20'h0C350);
        chk("endrop_hold_a",  amp_pp,    12'hC00);
        en = 1'b1;
        square(12'h100, 12'hF00, 125, 10);
        chk("reen_count", nvalid,    1);
        chk("reen_freq",  meas_freq, 20'h09C40);
        chk("reen_amp",   amp_pp,    12'hE00);

        // flat input at mid: timeout after MAX_PER+1 cycles in ARM
        en = 1'b0;
        step(12'h800, 3);
        en = 1'b1;
        nvalid = 0;
        step(12'h800, 2001);
        chk("nosig_before", no_signal, 0);
        step(12'h800, 1);
        chk("nosig_set", no_signal, 1);
        step(12'h800, 2100);
        chk("nosig_repeat", no_signal, 1);
        square(12'h100, 12'hF00, 125, 1);
        chk("nosig_sticky", no_signal, 1);
        square(12'h100, 12'hF00, 125, 9);
        chk("nosig_valid",   nvalid,    1);
        chk("nosig_cleared", no_signal, 0);
        chk("nosig_freq",    meas_freq, 20'h09C40);

        // spike adds a 10-cycle period inside the window
        restart(12'h100);
        nvalid  = 0;
        nglitch = 0;
        square(12'h100, 12'hF00, 125, 2);
        step(12'h100, 105);
        step(12'hF00, 5);
        step(12'h100, 5);
        step(12'hF00, 125);
        chk("glitch_pulse",    nglitch, 1);
        chk("glitch_noupdate", nvalid,  0);
        square(12'h100, 12'hF00, 125, 9);
        chk("glitch_recover", nvalid,    1);
        chk("glitch_freq",    meas_freq, 20'h09C40);
        chk("glitch_once",    nglitch,   1);

        // asynchronous reset while dividing
        restart(12'h100);
        nvalid = 0;
        square(12'h100, 12'hF00, 125, 8);
        step(12'h100, 125);
        step(12'hF00, 10);
        chk("div_busy",    busy,      1);
        chk("div_freq",    meas_freq, 20'h09C40);
        chk("div_novalid", nvalid,    0);
        #2 nrst = 1'b0;
        #1;
        chk("arst_freq",  meas_freq,  0);
        chk("arst_amp",   amp_pp,     0);
        chk("arst_busy",  busy,       0);
        chk("arst_valid", meas_valid, 0);
        chk("arst_nosig", no_signal,  0);
        @(negedge clk);
        nrst = 1'b1;
        step(12'hF00, 115);
        square(12'h100, 12'hF00, 125, 10);
        chk("postrst_count", nvalid,    1);
        chk("postrst_freq",  meas_freq, 20'h09C40);
        chk("postrst_amp",   amp_pp,    12'hE00);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
`default_nettype wire
